// File: rtl/md5_digest_match.sv
// md5_digest_match: final stage of a brute-force MD5 search pipeline.
// Adds the MD5 IV to each finished 64-round result, compares the digest
// against a static target, and hands the matching candidate index to the
// consumer through a simple found/ack handshake. One candidate per cycle.
module md5_digest_match #(
    parameter int IDX_WIDTH = 48
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 valid_in,
    input  logic [31:0]          a_in,
    input  logic [31:0]          b_in,
    input  logic [31:0]          c_in,
    input  logic [31:0]          d_in,
    input  logic [127:0]         target,
    input  logic                 match_ack,
    output logic                 match_found,
    output logic [IDX_WIDTH-1:0] match_index,
    output logic                 multi_hit,
    output logic [IDX_WIDTH-1:0] tested_count,
    output logic                 wrapped
);

    // MD5 initial chaining values, added back after the last round
    localparam logic [31:0] IV_A = 32'h6745_2301;
    localparam logic [31:0] IV_B = 32'hefcd_ab89;
    localparam logic [31:0] IV_C = 32'h98ba_dcfe;
    localparam logic [31:0] IV_D = 32'h1032_5476;

    localparam logic [IDX_WIDTH-1:0] IDX_ONE  = {{(IDX_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [IDX_WIDTH-1:0] IDX_ONES = {IDX_WIDTH{1'b1}};

    // Match-reporting FSM encoding
    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_FOUND = 1'b1;

    // Stage 1 registers
    logic [31:0]          a1, b1, c1, d1;
    logic                 valid1;
    logic [IDX_WIDTH-1:0] idx1;

    // Stage 2 registers
    logic                 hit2;
    logic [IDX_WIDTH-1:0] idx2;

    logic                 state;

    // A candidate is accepted (counted and pushed into the pipe) only when not clearing
    logic accept;
    assign accept = valid_in & ~clear;

    // Stage 1 datapath: digest words = round output + IV
    // NOTE: these word registers carry no reset; valid1 qualifies them, so
    // their power-up contents are never observed and the reset tree stays small.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        a1 <= a_in + IV_A;
        b1 <= b_in + IV_B;
        c1 <= c_in + IV_C;
        d1 <= d_in + IV_D;
    end

    // Stage 1 control: valid flag, candidate index, arrival counter and wrap flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid1       <= 1'b0;
            idx1         <= '0;
            tested_count <= '0;
            wrapped      <= 1'b0;
        end else if (clear) begin
            valid1       <= 1'b0;
            idx1         <= '0;
            tested_count <= '0;
            wrapped      <= 1'b0;
        end else begin
            valid1 <= valid_in;
            idx1   <= tested_count;
            if (accept) begin
                tested_count <= tested_count + IDX_ONE;
                if (tested_count == IDX_ONES) begin
                    wrapped <= 1'b1;
                end
            end
        end
    end

    // Stage 2: full 128-bit compare against the target digest
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit2 <= 1'b0;
            idx2 <= '0;
        end else if (clear) begin
            hit2 <= 1'b0;
            idx2 <= '0;
        end else begin
            hit2 <= valid1 && ({a1, b1, c1, d1} == target);
            idx2 <= idx1;
        end
    end

    // Match FSM: capture first hit, flag extra hits, release on ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            match_index <= '0;
            multi_hit   <= 1'b0;
        end else if (clear) begin
            state       <= ST_IDLE;
            match_index <= '0;
            multi_hit   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (hit2) begin
                        state       <= ST_FOUND;
                        match_index <= idx2;
                    end
                end
                ST_FOUND: begin
                    if (match_ack) begin
                        // Ack with a fresh hit hands over the new index directly
                        if (hit2) begin
                            match_index <= idx2;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else if (hit2) begin
                        multi_hit <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign match_found = (state == ST_FOUND);

endmodule
